mat_cache_reader: RTL and testbench

Read-side sequencer for the matrix cache: accepts a (base, count) burst command, drives the cache read port, and streams the returned `WIDTH`-lane `shortreal` rows to the consumer over a valid/ready handshake. An internal FIFO absorbs back-pressure, so the cache is never stalled mid-read and no row is dropped. It sits between the matrix-unit controller (command side) and the systolic datapath (row consumer).

---
 rtl/mat_cache_reader.sv | 151 +++++++++++++++
 tb/tb_mat_cache_reader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mat_cache_reader.sv
// Burst read sequencer: walks a cache address range and streams rows through a credit-managed FIFO.
// Lanes carry raw single-precision bit patterns. Define MAT_CACHE_READER_STRIDE_EN for a per-command stride port.
module mat_cache_reader #(
    parameter int WIDTH     = 128,
    parameter int CACHESIZE = 256,
    parameter int CACHEADDR = $clog2(CACHESIZE),
    parameter int FIFODEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [CACHEADDR-1:0] cmd_base,
    input  logic [CACHEADDR:0]   cmd_count,
`ifdef MAT_CACHE_READER_STRIDE_EN
    input  logic [CACHEADDR-1:0] cmd_stride,
`endif
    output logic                 cache_mode,
    output logic [CACHEADDR-1:0] cache_addr,
    input  logic [31:0]          cache_data [WIDTH],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_data [WIDTH],
    output logic                 done
);

    localparam int PW = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
    localparam int CW = $clog2(FIFODEPTH + 1);
    localparam int RW = CACHEADDR + 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFODEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFODEPTH);
    localparam logic [RW-1:0] SIZE_C   = RW'(CACHESIZE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t               state_q;
    logic [CACHEADDR-1:0] addr_q, addr_d, stride;
    logic [RW-1:0]        remain_q, addrSum, addrWrap;
    logic                 inflight_q, done_q;
    logic [PW-1:0]        rdPtr_q, wrPtr_q;
    logic [CW-1:0]        fifoCount_q, fifoCount_d;
    logic [31:0]          mem [FIFODEPTH][WIDTH];
    logic                 issue, push, pop, lastPop;

`ifdef MAT_CACHE_READER_STRIDE_EN
    logic [CACHEADDR-1:0] stride_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stride_q <= '0;
        end else if (state_q == IDLE && cmd_valid) begin
            stride_q <= cmd_stride;
        end
    end

    assign stride = stride_q;
`else
    assign stride = CACHEADDR'(1);
`endif

    // Address steps modulo CACHESIZE, which need not be a power of two.
    assign addrSum  = {1'b0, addr_q} + {1'b0, stride};
    assign addrWrap = addrSum - SIZE_C;
    assign addr_d   = (addrSum >= SIZE_C) ? addrWrap[CACHEADDR-1:0] : addrSum[CACHEADDR-1:0];

    assign out_valid = (fifoCount_q != '0);
    assign push      = inflight_q;
    assign pop       = out_valid && out_ready;
    // Credit uses start-of-cycle occupancy so an in-flight row always has a free slot.
    assign issue     = (state_q == RUN) && ((fifoCount_q + CW'(inflight_q)) < DEPTH_C);
    assign lastPop   = (state_q == DRAIN) && pop && !inflight_q && (fifoCount_q == CW'(1));

    always_comb begin
        fifoCount_d = fifoCount_q;
        case ({push, pop})
            2'b10:   fifoCount_d = fifoCount_q + CW'(1);
            2'b01:   fifoCount_d = fifoCount_q - CW'(1);
            default: fifoCount_d = fifoCount_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            inflight_q  <= 1'b0;
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            fifoCount_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            inflight_q  <= issue;
            fifoCount_q <= fifoCount_d;
            if (push) begin
                wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_base;
                        remain_q <= cmd_count;
                        if (cmd_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        addr_q   <= addr_d;
                        remain_q <= remain_q - RW'(1);
                        if (remain_q == RW'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (lastPop) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wrPtr_q] <= cache_data;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            out_data[i] = out_valid ? mem[rdPtr_q][i] : 32'h0;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign cache_mode = 1'b0;
    assign cache_addr = addr_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mat_cache_reader.sv
// Self-checking bench for mat_cache_reader: vector table of bursts, row scoreboard and a mid-burst reset sequence.
// Honours MAT_CACHE_READER_STRIDE_EN when it is defined for the design build.
module tb_mat_cache_reader;

    localparam int WIDTH     = 128;
    localparam int CACHESIZE = 256;
    localparam int AW        = 8;
    localparam int CW        = AW + 1;
    localparam int FIFODEPTH = 4;

    typedef struct {
        int base;
        int count;
        int stride;
        int lowCycles;
        int expDone;
    } vector_t;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          cmdValid = 1'b0;
    logic          cmdReady;
    logic [AW-1:0] cmdBase  = '0;
    logic [CW-1:0] cmdCount = '0;
`ifdef MAT_CACHE_READER_STRIDE_EN
    logic [AW-1:0] cmdStride = '0;
`endif
    logic          cacheMode;
    logic [AW-1:0] cacheAddr;
    logic [31:0]   cacheData [WIDTH];
    logic          outValid;
    logic          outReady = 1'b0;
    logic [31:0]   outData [WIDTH];
    logic          done;

    int            testsRun    = 0;
    int            testsFailed = 0;
    logic [AW-1:0] sbQueue [$];
    vector_t       vectors [7];

    mat_cache_reader dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmdValid),
        .cmd_ready  (cmdReady),
        .cmd_base   (cmdBase),
        .cmd_count  (cmdCount),
`ifdef MAT_CACHE_READER_STRIDE_EN
        .cmd_stride (cmdStride),
`endif
        .cache_mode (cacheMode),
        .cache_addr (cacheAddr),
        .cache_data (cacheData),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_data   (outData),
        .done       (done)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] laneVal(input logic [AW-1:0] a, input int l);
        logic [7:0] lb;
        lb = l[7:0];
        return {a ^ 8'h3F, lb, ~a, lb * 8'd7};
    endfunction

    function automatic logic [AW-1:0] expAddr(input int base, input int stride, input int i);
        return AW'((base + i * stride) % CACHESIZE);
    endfunction

    // Synchronous cache model: data for an address appears in the following cycle.
    always @(posedge clock) begin
        for (int l = 0; l < WIDTH; l++) begin
            cacheData[l] <= laneVal(cacheAddr, l);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkRow(input logic [AW-1:0] addr);
        int badLane = -1;
        for (int l = 0; l < WIDTH; l++) begin
            if (badLane < 0 && outData[l] !== laneVal(addr, l)) badLane = l;
        end
        testsRun++;
        if (badLane >= 0) begin
            testsFailed++;
            $display("[TB] FAIL row %0d lane %0d: got %h, expected %h", addr, badLane,
                     outData[badLane], laneVal(addr, badLane));
        end
    endtask

    task automatic checkResetOutputs(input string prefix);
        logic [31:0] orAll = '0;
        for (int l = 0; l < WIDTH; l++) orAll |= outData[l];
        checkOutput({prefix, ".cmdReady"}, cmdReady, 1);
        checkOutput({prefix, ".outValid"}, outValid, 0);
        checkOutput({prefix, ".done"}, done, 0);
        checkOutput({prefix, ".cacheMode"}, cacheMode, 0);
        checkOutput({prefix, ".cacheAddr"}, cacheAddr, 0);
        checkOutput({prefix, ".outData"}, orAll, 0);
    endtask

    // One cycle: drop the command, set ready, and score any row handshaking at the coming edge.
    task automatic stepCycle(input logic rdy);
        @(negedge clock);
        cmdValid = 1'b0;
        outReady = rdy;
        if (outValid && outReady) begin
            if (sbQueue.size() == 0) checkOutput("unexpectedRow", 1, 0);
            else checkRow(sbQueue.pop_front());
        end
    endtask

    task automatic waitIdle();
        int guard = 0;
        while (!cmdReady && guard < 400) begin
            @(negedge clock);
            guard++;
        end
        if (!cmdReady) begin
            checkOutput("idleTimeout", 0, 1);
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
        end
        sbQueue.delete();
    endtask

    task automatic applyStimulus(input vector_t v);
        int stride;
        int addrChecks;
`ifdef MAT_CACHE_READER_STRIDE_EN
        stride = v.stride;
`else
        stride = 1;
`endif
        waitIdle();
        @(negedge clock);
        cmdValid = 1'b1;
        cmdBase  = AW'(v.base);
        cmdCount = CW'(v.count);
`ifdef MAT_CACHE_READER_STRIDE_EN
        cmdStride = AW'(v.stride);
`endif
        outReady = (v.lowCycles == 0);
        for (int i = 0; i < v.count; i++) sbQueue.push_back(expAddr(v.base, stride, i));
        addrChecks = (v.lowCycles == 0 || v.count < FIFODEPTH) ? v.count : FIFODEPTH;
        for (int k = 1; k <= v.expDone + 1; k++) begin
            stepCycle(k > v.lowCycles);
            checkOutput("cmdReady", cmdReady, k >= v.expDone);
            checkOutput("done", done, k == v.expDone);
            if (k <= addrChecks) checkOutput("addr", cacheAddr, expAddr(v.base, stride, k - 1));
            if (v.lowCycles > 0 && v.count > FIFODEPTH && k == v.lowCycles)
                checkOutput("stallAddr", cacheAddr, expAddr(v.base, stride, FIFODEPTH));
            if (v.lowCycles == 0)
                checkOutput("outValid", outValid, v.count > 0 && k >= 3 && k <= v.count + 2);
        end
        checkOutput("rowsLeft", sbQueue.size(), 0);
    endtask

    initial begin
        vectors[0] = '{base: 5,   count: 4,   stride: 1,   lowCycles: 0,  expDone: 7};
        vectors[1] = '{base: 254, count: 4,   stride: 1,   lowCycles: 0,  expDone: 7};
        vectors[2] = '{base: 0,   count: 0,   stride: 1,   lowCycles: 0,  expDone: 1};
        vectors[3] = '{base: 100, count: 8,   stride: 1,   lowCycles: 10, expDone: 19};
        vectors[4] = '{base: 255, count: 1,   stride: 1,   lowCycles: 0,  expDone: 4};
        vectors[5] = '{base: 3,   count: 256, stride: 1,   lowCycles: 0,  expDone: 259};
        vectors[6] = '{base: 10,  count: 4,   stride: 100, lowCycles: 0,  expDone: 7};

        repeat (3) @(negedge clock);
        checkResetOutputs("reset");
        reset = 1'b0;

        foreach (vectors[i]) applyStimulus(vectors[i]);

        // Abort a burst after three rows, then start a fresh one right after reset.
        waitIdle();
        @(negedge clock);
        cmdValid = 1'b1;
        cmdBase  = 8'd40;
        cmdCount = 9'd8;
`ifdef MAT_CACHE_READER_STRIDE_EN
        cmdStride = 8'd1;
`endif
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) sbQueue.push_back(expAddr(40, 1, i));
        for (int k = 1; k <= 5; k++) stepCycle(1'b1);
        checkOutput("rowsBeforeReset", sbQueue.size(), 5);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkResetOutputs("midReset");
        sbQueue.delete();
        @(negedge clock);
        reset = 1'b0;
        checkOutput("postResetReady", cmdReady, 1);
        cmdValid = 1'b1;
        cmdBase  = 8'd7;
        cmdCount = 9'd2;
        outReady = 1'b1;
        sbQueue.push_back(8'd7);
        sbQueue.push_back(8'd8);
        for (int k = 1; k <= 6; k++) begin
            stepCycle(1'b1);
            checkOutput("postResetDone", done, k == 5);
            if (k <= 2) checkOutput("postResetAddr", cacheAddr, 7 + k - 1);
        end
        checkOutput("postResetRowsLeft", sbQueue.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
